// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: decodes the IR in DECODE and sequences
// fetch/decode/execute/memory/writeback plus a counted multiply/divide wait.
module mc_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int MEM_WAIT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        eq,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic        hilo_we,
    output logic        md_busy,
    output logic        md_op,
    output logic        hilo_rd,
    output logic [1:0]  pcsel,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic        alusrc,
    output logic [1:0]  extop,
    output logic [1:0]  aluop,
    output logic [2:0]  state
);

    localparam int MD_MAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_MAX = (MD_MAX > MEM_WAIT + 1) ? MD_MAX : MEM_WAIT + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NOP  = 4'd0,  C_ADD  = 4'd1,  C_SUB  = 4'd2,  C_JR   = 4'd3,
        C_MULT = 4'd4,  C_DIV  = 4'd5,  C_MFHI = 4'd6,  C_MFLO = 4'd7,
        C_ORI  = 4'd8,  C_LUI  = 4'd9,  C_LW   = 4'd10, C_SW   = 4'd11,
        C_BEQ  = 4'd12, C_JAL  = 4'd13
    } cls_t;

    function automatic cls_t decode_instr(input logic [5:0] op, input logic [5:0] func);
        cls_t c;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: c = C_ADD;
                    6'b100010: c = C_SUB;
                    6'b001000: c = C_JR;
                    6'b011000: c = C_MULT;
                    6'b011010: c = C_DIV;
                    6'b010000: c = C_MFHI;
                    6'b010010: c = C_MFLO;
                    default:   c = C_NOP;
                endcase
            end
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000011: c = C_JAL;
            default:   c = C_NOP;
        endcase
        return c;
    endfunction

    state_t        cur;
    cls_t          cls;
    cls_t          dec;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          unused_bits;

    assign dec         = decode_instr(instr[31:26], instr[5:0]);
    assign cnt_zero    = (cnt == {CW{1'b0}});
    assign state       = cur;
    assign unused_bits = ^instr[25:6];

    // State sequencing, class latch and the shared MEM/MDWAIT wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= S_FETCH;
            cls <= C_NOP;
            cnt <= {CW{1'b0}};
        end else begin
            case (cur)
                S_FETCH: cur <= S_DECODE;
                S_DECODE: begin
                    cls <= dec;
                    case (dec)
                        C_JAL:       cur <= S_WB;
                        C_JR, C_NOP: cur <= S_FETCH;
                        default:     cur <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        C_BEQ: cur <= S_FETCH;
                        C_LW, C_SW: begin
                            cnt <= CW'(MEM_WAIT);
                            cur <= S_MEM;
                        end
                        C_MULT: begin
                            cnt <= CW'(MULT_CYCLES - 1);
                            cur <= S_MDWAIT;
                        end
                        C_DIV: begin
                            cnt <= CW'(DIV_CYCLES - 1);
                            cur <= S_MDWAIT;
                        end
                        default: cur <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (cnt_zero) begin
                        cur <= (cls == C_SW) ? S_FETCH : S_WB;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WB: cur <= S_FETCH;
                S_MDWAIT: begin
                    if (cnt_zero) begin
                        cur <= S_FETCH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: cur <= S_FETCH;
            endcase
        end
    end

    // Write enables and PC select; jr redirects from DECODE before its class is latched
    always_comb begin
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        hilo_we = 1'b0;
        md_busy = 1'b0;
        pcsel   = 2'd0;
        if (reset) begin
            pc_we = 1'b0;
        end else begin
            case (cur)
                S_FETCH: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                S_DECODE: begin
                    if (dec == C_JR) begin
                        pc_we = 1'b1;
                        pcsel = 2'd3;
                    end else begin
                        pc_we = 1'b0;
                    end
                end
                S_EXEC: begin
                    if (cls == C_BEQ) begin
                        pc_we = eq;
                        pcsel = 2'd1;
                    end else begin
                        pc_we = 1'b0;
                    end
                end
                S_MEM: begin
                    if (cnt_zero && (cls == C_SW)) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_we = 1'b0;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    if (cls == C_JAL) begin
                        pc_we = 1'b1;
                        pcsel = 2'd2;
                    end else begin
                        pc_we = 1'b0;
                    end
                end
                S_MDWAIT: begin
                    md_busy = 1'b1;
                    if (cnt_zero) begin
                        hilo_we = 1'b1;
                    end else begin
                        hilo_we = 1'b0;
                    end
                end
                default: pc_we = 1'b0;
            endcase
        end
    end

    // Datapath selects depend only on the latched class
    always_comb begin
        regdst   = 2'd0;
        memtoreg = 2'd0;
        alusrc   = 1'b0;
        extop    = 2'd0;
        aluop    = 2'd0;
        hilo_rd  = 1'b0;
        md_op    = 1'b0;
        case (cls)
            C_ADD: regdst = 2'd1;
            C_SUB: begin
                regdst = 2'd1;
                aluop  = 2'd1;
            end
            C_MFHI: begin
                regdst   = 2'd1;
                memtoreg = 2'd3;
            end
            C_MFLO: begin
                regdst   = 2'd1;
                memtoreg = 2'd3;
                hilo_rd  = 1'b1;
            end
            C_ORI: begin
                alusrc = 1'b1;
                aluop  = 2'd2;
            end
            C_LUI: begin
                alusrc = 1'b1;
                extop  = 2'd2;
            end
            C_LW: begin
                alusrc   = 1'b1;
                extop    = 2'd1;
                memtoreg = 2'd1;
            end
            C_SW: begin
                alusrc = 1'b1;
                extop  = 2'd1;
            end
            C_BEQ: begin
                extop = 2'd1;
                aluop = 2'd3;
            end
            C_JAL: begin
                regdst   = 2'd2;
                memtoreg = 2'd2;
            end
            C_DIV: md_op = 1'b1;
            default: md_op = 1'b0;
        endcase
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS core: decodes the instruction held in the IR and sequences the datapath through fetch, decode, execute, memory and writeback. Each instruction class takes a different number of cycles. It extends the single-cycle decoder by adding mult/div/mfhi/mflo with a parametrised multiply/divide latency and parametrised memory wait states. It sits between the IR and the PC/IR/GRF/DM/HILO write enables and datapath muxes.

## Interface
- MULT_CYCLES, 5: cycles spent in MDWAIT for mult (>=1)
- DIV_CYCLES, 10: cycles spent in MDWAIT for div (>=1)
- MEM_WAIT, 0: extra cycles in MEM beyond the first (>=0)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH and clears all registers
- instr  in  32  IR contents; sampled in DECODE only
- eq  in  1  ALU equality flag; sampled in EXEC for beq
- pc_we  out  1  PC write enable
- ir_we  out  1  IR write enable
- reg_we  out  1  GRF write enable
- mem_we  out  1  DM write enable
- hilo_we  out  1  HI/LO write enable
- md_busy  out  1  high in every MDWAIT cycle
- md_op  out  1  0 mult, 1 div
- hilo_rd  out  1  0 HI, 1 LO (mfhi/mflo source)
- pcsel  out  2  0 PC+4, 1 BEQ target, 2 JAL target, 3 rs (jr)
- regdst  out  2  0 rt, 1 rd, 2 $31
- memtoreg  out  2  0 ALU, 1 DM, 2 PC, 3 HI/LO
- alusrc  out  1  0 rt, 1 extended imm
- extop  out  2  0 zero-ext, 1 sign-ext, 2 lui (imm<<16)
- aluop  out  2  0 add, 1 sub, 2 or, 3 equal
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5

## Operation
- Decoded set: add (op 0, func 100000), sub (100010), jr (001000), mult (011000), div (011010), mfhi (010000), mflo (010010); ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011.
- Any other encoding decodes as nop.
- The decoded class is latched into a register at the DECODE edge. All mux and select outputs are combinational from this latched class only. They stay stable from EXEC until the next DECODE.
- FETCH: ir_we=1, pc_we=1, pcsel=0 -> DECODE.
- DECODE:
  - jal -> WB.
  - jr: pc_we=1, pcsel=3 -> FETCH.
  - nop -> FETCH.
  - All others -> EXEC.
- EXEC:
  - beq: pc_we=eq, pcsel=1 -> FETCH.
  - lw/sw -> MEM; the wait counter loads MEM_WAIT.
  - mult/div -> MDWAIT; the counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - add/sub/ori/lui/mfhi/mflo -> WB.
- MEM: counter decrements each cycle.
  - When the counter is 0: sw asserts mem_we=1 for that single cycle and goes -> FETCH; lw goes -> WB.
- WB:
  - reg_we=1 -> FETCH.
  - For jal, also pc_we=1, pcsel=2, regdst=2, memtoreg=2.
- MDWAIT: md_busy=1, counter decrements each cycle.
  - When the counter is 0: hilo_we=1 -> FETCH.
- Selects per class:
  - add/sub: regdst=1.
  - ori/lui/lw/sw: alusrc=1.
  - lw/sw: extop=1; lui: extop=2; beq: extop=1.
  - sub: aluop=1; ori: aluop=2; beq: aluop=3.
  - lw: memtoreg=1; mfhi/mflo: memtoreg=3, regdst=1.
  - mflo: hilo_rd=1; div: md_op=1.
- Defaults for every select not listed: 0.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES, MEM_WAIT+1)+1).
- Write enables are asserted only in the states listed above; they are 0 in all other states.

## Timing
- Reset (asserted): state=FETCH, counter=0, latched class=nop.
  - All enables and md_busy are forced to 0 while reset is high, including the FETCH enables.
  - All select outputs are 0.
  - The first FETCH enables appear in the cycle after reset is released.
- Cycles per instruction:
  - add/sub/ori/lui/mfhi/mflo: 4.
  - lw: 5+MEM_WAIT; sw: 4+MEM_WAIT.
  - beq: 3 (taken or not).
  - jal: 3; jr: 2; nop: 2.
  - mult: 3+MULT_CYCLES; div: 3+DIV_CYCLES.
- Exactly one write enable among reg_we/mem_we/hilo_we is high per instruction, for one cycle; none is high for beq/jr/nop.
- Reset mid-MEM or mid-MDWAIT: the instruction is abandoned in the same cycle.
  - No mem_we or hilo_we pulse occurs afterwards.
  - The counter clears to 0.
- instr changes outside DECODE have no effect on outputs.

## Test plan
- Defaults, add (op 0, func 100000): state sequence 0,1,2,4,0. reg_we=1 only in WB with regdst=1. ir_we=pc_we=1 only in FETCH.
- lw with MEM_WAIT=2: MEM occupies 3 cycles, then WB with reg_we=1, memtoreg=1, extop=1, alusrc=1. Total 7 cycles.
- sw with MEM_WAIT=2: mem_we=1 only in the 3rd MEM cycle, then FETCH, reg_we never 1. Total 6 cycles.
- beq with eq=1, then eq=0: the first gives pc_we=1, pcsel=1 in EXEC; the second gives pc_we=0. Both return to FETCH after 3 cycles.
- mult, MULT_CYCLES=5: md_busy high for exactly 5 cycles, with hilo_we=1 in the 5th, md_op=0. Next FETCH follows at cycle 8. Repeat with div, DIV_CYCLES=10: md_busy for 10 cycles, md_op=1.
- Reset for 1 cycle during the 3rd MDWAIT cycle of div: state=0 immediately, hilo_we never pulses. A subsequent jal gives 0,1,4 with pc_we=1, pcsel=2, reg_we=1, regdst=2 in WB. Unknown opcode 111111 gives 0,1,0.
